eu_icon_tx_port: RTL and testbench



---
 rtl/eu_icon_tx_port_pkg.sv | 22 ++
 rtl/icon_tx_fifo.sv | 56 +++++
 rtl/eu_icon_tx_port.sv | 124 ++++++++++++
 tb/tb_eu_icon_tx_port.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eu_icon_tx_port_pkg.sv
// rtl/eu_icon_tx_port_pkg.sv - shared interconnect channel types for execution-unit endpoints
package exec_unit_dtypes;

  localparam int ICON_DATA_WIDTH = 16;
  localparam int ICON_TAG_WIDTH  = 4;
  // Wide enough for up to 16 units; each port zero-extends its UNIT_ID into it.
  localparam int ICON_SRC_WIDTH  = 4;

  typedef struct packed {
    logic                       valid;
    logic [ICON_SRC_WIDTH-1:0]  src;
    logic [ICON_TAG_WIDTH-1:0]  tag;
    logic [ICON_DATA_WIDTH-1:0] data;
  } type_icon_channel;

  typedef enum logic [1:0] {
    ICON_TX_IDLE = 2'd0,
    ICON_TX_REQ  = 2'd1,
    ICON_TX_SEND = 2'd2
  } type_icon_tx_state;

endpackage

// File: rtl/icon_tx_fifo.sv
// rtl/icon_tx_fifo.sv - synchronous FIFO with count, shared by interconnect tx/rx endpoints
module icon_tx_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/eu_icon_tx_port.sv
// rtl/eu_icon_tx_port.sv - per-EU transmit endpoint: buffers results, bids with aging priority, drives granted channel
module eu_icon_tx_port
  import exec_unit_dtypes::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int NUM_UNITS    = 2,
  parameter int UNIT_ID      = 0,
  parameter int FIFO_DEPTH   = 4,
  localparam int ARB_CH_WIDTH = $clog2(NUM_UNITS)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                eu_valid,
  output logic                                eu_ready,
  input  logic [ICON_TAG_WIDTH-1:0]           eu_tag,
  input  logic [ICON_DATA_WIDTH-1:0]          eu_data,
  output logic                                req_valid,
  output logic [ARB_CH_WIDTH-1:0]             req_prio,
  input  logic [NUM_CHANNELS-1:0]             grant,
  output type_icon_channel [NUM_CHANNELS-1:0] ch_out,
  output logic                                err_spurious_grant
);

  localparam int CH_SEL_W = $clog2(NUM_CHANNELS);
  localparam int PAY_W    = ICON_TAG_WIDTH + ICON_DATA_WIDTH;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  type_icon_tx_state     state_q, state_d;
  logic [ARB_CH_WIDTH-1:0] prio_q, prio_d;
  logic [CH_SEL_W-1:0]   ch_sel_q, ch_sel_d;
  logic                  err_q, err_d;
  logic [CH_SEL_W-1:0]   grant_idx;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAY_W-1:0]      fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  assign eu_ready  = !fifo_full;
  assign fifo_push = eu_valid && eu_ready;

  icon_tx_fifo #(
    .WIDTH (PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({eu_tag, eu_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Lowest set grant bit wins when the arbiter hands out several channels.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (grant[i]) grant_idx = CH_SEL_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    ch_sel_d = ch_sel_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ICON_TX_IDLE: begin
        if (grant != '0) err_d = 1'b1;
        if (!fifo_empty || fifo_push) state_d = ICON_TX_REQ;
      end
      ICON_TX_REQ: begin
        if (grant != '0) begin
          ch_sel_d = grant_idx;
          state_d  = ICON_TX_SEND;
        end else if (prio_q != '0) begin
          prio_d = prio_q - ARB_CH_WIDTH'(1);
        end
      end
      ICON_TX_SEND: begin
        if (grant != '0) err_d = 1'b1;
        fifo_pop = 1'b1;
        prio_d   = ARB_CH_WIDTH'(UNIT_ID);
        // A push landing in the same cycle as the pop keeps us bidding.
        if (fifo_count > CNT_W'(1) || fifo_push) state_d = ICON_TX_REQ;
        else                                     state_d = ICON_TX_IDLE;
      end
      default: state_d = ICON_TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ICON_TX_IDLE;
      prio_q   <= ARB_CH_WIDTH'(UNIT_ID);
      ch_sel_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      ch_sel_q <= ch_sel_d;
      err_q    <= err_d;
    end
  end

  assign req_valid          = (state_q == ICON_TX_REQ);
  assign req_prio           = prio_q;
  assign err_spurious_grant = err_q;

  // Undriven entries stay all-zero so the interconnect can OR-combine ports.
  always_comb begin
    ch_out = '0;
    if (state_q == ICON_TX_SEND) begin
      ch_out[ch_sel_q].valid = 1'b1;
      ch_out[ch_sel_q].src   = ICON_SRC_WIDTH'(UNIT_ID);
      ch_out[ch_sel_q].tag   = fifo_head[PAY_W-1:ICON_DATA_WIDTH];
      ch_out[ch_sel_q].data  = fifo_head[ICON_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_eu_icon_tx_port.sv
// tb/tb_eu_icon_tx_port.sv - directed scoreboard bench for eu_icon_tx_port
module tb_eu_icon_tx_port;
  import exec_unit_dtypes::*;

  localparam int NCH   = 2;
  localparam int NU    = 4;
  localparam int UID   = 3;
  localparam int DEPTH = 4;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        eu_valid = 1'b0;
  logic                        eu_ready;
  logic [ICON_TAG_WIDTH-1:0]   eu_tag = '0;
  logic [ICON_DATA_WIDTH-1:0]  eu_data = '0;
  logic                        req_valid;
  logic [1:0]                  req_prio;
  logic [NCH-1:0]              grant = '0;
  type_icon_channel [NCH-1:0]  ch_out;
  logic                        err_spurious_grant;

  eu_icon_tx_port #(
    .NUM_CHANNELS (NCH),
    .NUM_UNITS    (NU),
    .UNIT_ID      (UID),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .eu_valid           (eu_valid),
    .eu_ready           (eu_ready),
    .eu_tag             (eu_tag),
    .eu_data            (eu_data),
    .req_valid          (req_valid),
    .req_prio           (req_prio),
    .grant              (grant),
    .ch_out             (ch_out),
    .err_spurious_grant (err_spurious_grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  int emitted = 0;
  int last_ch = -1;
  type_icon_channel sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and scoreboard whatever the port drives in the new cycle.
  task automatic tick();
    int nval;
    int vch;
    type_icon_channel vword;
    type_icon_channel exp_w;
    @(posedge clk);
    #1;
    nval = 0;
    vch = 0;
    vword = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_out[c].valid) begin
        nval++;
        vch = c;
        vword = ch_out[c];
      end
    end
    if (nval != 0) begin
      emitted++;
      last_ch = vch;
      chk("one_channel_driven", 64'(nval), 64'(1));
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed=%0h expected=none", vword);
      end else begin
        exp_w = sb.pop_front();
        chk("ch_word", 64'(vword), 64'(exp_w));
        model_cnt--;
      end
    end
  endtask

  task automatic push(input logic [3:0] tag, input logic [15:0] data);
    type_icon_channel e;
    eu_valid = 1'b1;
    eu_tag   = tag;
    eu_data  = data;
    if (model_cnt < DEPTH) begin
      e.valid = 1'b1;
      e.src   = ICON_SRC_WIDTH'(UID);
      e.tag   = tag;
      e.data  = data;
      sb.push_back(e);
      model_cnt++;
    end
    tick();
    eu_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(req_valid), 64'(1));
  endtask

  task automatic grant_once(input logic [NCH-1:0] g);
    grant = g;
    tick();
    grant = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int cyc;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_eu_ready", 64'(eu_ready), 64'(1));
    chk("rst_req_valid", 64'(req_valid), 64'(0));
    chk("rst_req_prio", 64'(req_prio), 64'(UID));
    chk("rst_ch_out", 64'(ch_out), 64'(0));
    chk("rst_err", 64'(err_spurious_grant), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single result on channel 0
    push(4'd3, 16'hA5A5);
    chk("t1_req_next_cycle", 64'(req_valid), 64'(1));
    chk("t1_prio", 64'(req_prio), 64'(UID));
    e0 = emitted;
    grant_once(2'b01);
    chk("t1_emitted", 64'(emitted - e0), 64'(1));
    chk("t1_ch", 64'(last_ch), 64'(0));
    chk("t1_ch1_zero", 64'(ch_out[1]), 64'(0));
    chk("t1_send_no_req", 64'(req_valid), 64'(0));
    tick();
    chk("t1_one_cycle", 64'(ch_out), 64'(0));
    chk("t1_idle", 64'(req_valid), 64'(0));
    chk("t1_fifo_empty", 64'(eu_ready), 64'(1));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));

    // Aging priority
    push(4'd1, 16'h1111);
    chk("age_k0", 64'(req_prio), 64'(3));
    tick();
    chk("age_k1", 64'(req_prio), 64'(2));
    tick();
    chk("age_k2", 64'(req_prio), 64'(1));
    tick();
    chk("age_k3", 64'(req_prio), 64'(0));
    tick();
    chk("age_k4", 64'(req_prio), 64'(0));
    chk("age_still_req", 64'(req_valid), 64'(1));
    grant_once(2'b10);
    chk("age_ch1", 64'(last_ch), 64'(1));
    tick();
    chk("age_prio_restored", 64'(req_prio), 64'(UID));

    // Fill, overflow, drain at full rate
    push(4'd4, 16'h0004);
    push(4'd5, 16'h0005);
    push(4'd6, 16'h0006);
    push(4'd7, 16'h0007);
    chk("fill_not_ready", 64'(eu_ready), 64'(0));
    push(4'd8, 16'h0008);
    chk("fill_dropped_model", 64'(model_cnt), 64'(4));
    e0 = emitted;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_req", 64'(req_valid), 64'(1));
      grant_once(2'b01);
      tick();
      cyc += 2;
    end
    chk("drain_count", 64'(emitted - e0), 64'(4));
    chk("drain_cycles", 64'(cyc), 64'(8));
    chk("drain_idle", 64'(req_valid), 64'(0));
    chk("drain_ready", 64'(eu_ready), 64'(1));
    chk("drain_sb_empty", 64'(sb.size()), 64'(0));
    chk("err_clean", 64'(err_spurious_grant), 64'(0));

    // Multi-bit grant, then spurious grant
    push(4'd9, 16'h9999);
    wait_req("mg_req");
    grant_once(2'b11);
    chk("mg_ch0", 64'(last_ch), 64'(0));
    chk("mg_ch1_zero", 64'(ch_out[1]), 64'(0));
    chk("mg_no_err", 64'(err_spurious_grant), 64'(0));
    tick();
    e0 = emitted;
    grant_once(2'b10);
    chk("sp_err", 64'(err_spurious_grant), 64'(1));
    chk("sp_no_ch", 64'(ch_out), 64'(0));
    chk("sp_no_req", 64'(req_valid), 64'(0));
    tick();
    tick();
    chk("sp_err_sticky", 64'(err_spurious_grant), 64'(1));
    chk("sp_no_emit", 64'(emitted - e0), 64'(0));

    // Push during SEND with one entry
    push(4'd10, 16'hAAAA);
    wait_req("ps_req");
    grant_once(2'b01);
    chk("ps_in_send", 64'(ch_out[0].valid), 64'(1));
    push(4'd11, 16'hBBBB);
    chk("ps_back_to_req", 64'(req_valid), 64'(1));
    e0 = emitted;
    grant_once(2'b01);
    chk("ps_second_emit", 64'(emitted - e0), 64'(1));
    tick();
    chk("ps_idle", 64'(req_valid), 64'(0));

    // Reset in the middle of SEND
    push(4'd12, 16'hCCCC);
    wait_req("rs_req");
    grant_once(2'b01);
    chk("rs_in_send", 64'(ch_out[0].valid), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_async_zero", 64'(ch_out), 64'(0));
    sb.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("rs_req_low", 64'(req_valid), 64'(0));
    chk("rs_fifo_empty", 64'(eu_ready), 64'(1));
    chk("rs_err_cleared", 64'(err_spurious_grant), 64'(0));
    chk("rs_prio", 64'(req_prio), 64'(UID));
    tick();
    chk("rs_stays_idle", 64'(req_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
